// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: IV and round constants (also used by the round core),
// block-framing parameters, buffer and issue state encodings, and the padding helper.
package sha1_pkg;

    // Initial hash value; the round core always starts from these.
    localparam logic [31:0] IV_H0 = 32'h6745_2301;
    localparam logic [31:0] IV_H1 = 32'hEFCD_AB89;
    localparam logic [31:0] IV_H2 = 32'h98BA_DCFE;
    localparam logic [31:0] IV_H3 = 32'h1032_5476;
    localparam logic [31:0] IV_H4 = 32'hC3D2_E1F0;

    // Round constants, one per 20-round phase.
    localparam logic [31:0] K_0 = 32'h5A82_7999;
    localparam logic [31:0] K_1 = 32'h6ED9_EBA1;
    localparam logic [31:0] K_2 = 32'h8F1B_BCDC;
    localparam logic [31:0] K_3 = 32'hCA62_C1D6;

    localparam int FRAME_LEN  = 80;  // clocks per block, one round per clock
    localparam int PHASE_LEN  = 20;  // rounds between phase_advance7 pulses
    localparam int LOAD_WORDS = 16;  // schedule words loaded per block
    localparam int MAX_BYTES  = 55;  // largest message that fits one padded block

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, ISSUING} buf_state_t;
    typedef enum logic {ISS_IDLE, ISS_RUN} issue_state_t;

    // Final message word with the 0x80 marker placed after its n valid bytes.
    // For n = 4 the word is unchanged; the marker goes into the following word.
    function automatic logic [31:0] pad_last_word(input logic [31:0] w, input logic [2:0] n);
        case (n)
            3'd0:    return 32'h8000_0000;
            3'd1:    return {w[31:24], 24'h80_0000};
            3'd2:    return {w[31:16], 16'h8000};
            3'd3:    return {w[31:8], 8'h80};
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/sha1_msg_buffer.sv
// One ping-pong block buffer: collects message words, inserts SHA-1 padding and the bit
// length on the last word, drops overlong messages, and serves words to the issue side.
module sha1_msg_buffer
    import sha1_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,        // message word accepted into this buffer
    input  logic [31:0] msg_word,
    input  logic [2:0]  msg_bytes,
    input  logic        msg_last,
    input  logic        issue_start,  // issue side claims a FULL buffer
    input  logic        issue_done,   // issue side has read the last word
    input  logic [3:0]  rd_idx,
    output logic [31:0] rd_word,
    output logic        fill_ok,      // can take words (EMPTY or FILLING, including drop)
    output logic        full,
    output logic        complete,     // accepted last word of a message that fits
    output logic        err
);

    buf_state_t  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        drop_q, drop_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [LOAD_WORDS];
    logic [31:0] mem_d [LOAD_WORDS];
    logic [5:0]  total_bytes;
    logic [8:0]  bit_len;
    logic        overlong;

    assign total_bytes = {idx_q, 2'b00} + {3'b000, msg_bytes};
    assign bit_len     = {total_bytes, 3'b000};
    // A 15th word, or a last word pushing the total past the single-block limit.
    assign overlong    = (idx_q >= 4'd14) || (msg_last && (total_bytes > 6'(MAX_BYTES)));

    // Fill / drop / issue state transitions and next contents of the word store.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d  = state_q;
        idx_d    = idx_q;
        drop_d   = drop_q;
        err_d    = 1'b0;
        complete = 1'b0;
        for (int i = 0; i < LOAD_WORDS; i++) begin
            mem_d[i] = mem_q[i];
        end

        if (wr_en) begin
            if (drop_q || overlong) begin
                if (msg_last) begin
                    state_d = EMPTY;
                    idx_d   = '0;
                    drop_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    state_d = FILLING;
                    drop_d  = 1'b1;
                end
            end else if (msg_last) begin
                for (int i = 0; i < LOAD_WORDS; i++) begin
                    if (4'(i) == idx_q) begin
                        mem_d[i] = pad_last_word(msg_word, msg_bytes);
                    end else if ((4'(i) == idx_q + 4'd1) && (msg_bytes >= 3'd4)) begin
                        mem_d[i] = 32'h8000_0000;
                    end else if (4'(i) > idx_q) begin
                        mem_d[i] = 32'h0;
                    end
                end
                mem_d[LOAD_WORDS-1] = {23'd0, bit_len};
                state_d  = FULL;
                idx_d    = '0;
                complete = 1'b1;
            end else begin
                mem_d[idx_q] = msg_word;
                idx_d        = idx_q + 4'd1;
                state_d      = FILLING;
            end
        end

        if (issue_start && (state_q == FULL)) begin
            state_d = ISSUING;
        end
        if (issue_done && (state_q == ISSUING)) begin
            state_d = EMPTY;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= EMPTY;
            idx_q   <= '0;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

    // Word store.
    always_ff @(posedge clk) begin
        // NOTE: the store has no reset; every word is rewritten before a buffer can go FULL.
        for (int i = 0; i < LOAD_WORDS; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign rd_word = mem_q[rd_idx];
    assign fill_ok = (state_q == EMPTY) || (state_q == FILLING);
    assign full    = (state_q == FULL);
    assign err     = err_q;

endmodule

// File: rtl/sha1_block_feeder.sv
// SHA-1 block feeder: steers incoming messages into two alternating block buffers and
// issues each padded block to the round core as an 80-clock frame with load/phase strobes.
module sha1_block_feeder
    import sha1_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] msg_word,
    input  logic [2:0]  msg_bytes,
    input  logic        msg_last,
    input  logic        msg_valid,
    output logic        msg_ready,
    output logic        msg_err,
    output logic        load7,
    output logic        phase_advance7,
    output logic [31:0] din,
    output logic        frame_start
);

    logic         fill_sel_q, fill_sel_d;
    logic         issue_sel_q, issue_sel_d;
    issue_state_t ist_q, ist_d;
    logic [6:0]   fc_q, fc_d;
    logic         ready_en_q, ready_en_d;

    logic [1:0]   buf_wr, buf_start, buf_done;
    logic [1:0]   buf_fill_ok, buf_full, buf_complete, buf_err;
    logic [31:0]  buf_rd [2];
    logic [3:0]   rd_idx;
    logic         accept, running, other_sel;

    assign accept     = msg_valid && msg_ready;
    assign buf_wr     = {accept && fill_sel_q, accept && !fill_sel_q};
    assign ready_en_d = 1'b1;
    assign other_sel  = ~issue_sel_q;

    sha1_msg_buffer u_buf0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (buf_wr[0]),
        .msg_word    (msg_word),
        .msg_bytes   (msg_bytes),
        .msg_last    (msg_last),
        .issue_start (buf_start[0]),
        .issue_done  (buf_done[0]),
        .rd_idx      (rd_idx),
        .rd_word     (buf_rd[0]),
        .fill_ok     (buf_fill_ok[0]),
        .full        (buf_full[0]),
        .complete    (buf_complete[0]),
        .err         (buf_err[0])
    );

    sha1_msg_buffer u_buf1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (buf_wr[1]),
        .msg_word    (msg_word),
        .msg_bytes   (msg_bytes),
        .msg_last    (msg_last),
        .issue_start (buf_start[1]),
        .issue_done  (buf_done[1]),
        .rd_idx      (rd_idx),
        .rd_word     (buf_rd[1]),
        .fill_ok     (buf_fill_ok[1]),
        .full        (buf_full[1]),
        .complete    (buf_complete[1]),
        .err         (buf_err[1])
    );

    // Fill side moves to the other buffer once a message has been fully captured.
    always_comb begin
        fill_sel_d = fill_sel_q ^ (|buf_complete);
    end

    // Issue FSM: frame counter, buffer claim/release, back-to-back hand-over at fc 79.
    always_comb begin
        ist_d       = ist_q;
        fc_d        = fc_q;
        issue_sel_d = issue_sel_q;
        buf_start   = '0;
        buf_done    = '0;
        case (ist_q)
            ISS_IDLE: begin
                if (buf_full[issue_sel_q]) begin
                    ist_d                  = ISS_RUN;
                    fc_d                   = '0;
                    buf_start[issue_sel_q] = 1'b1;
                end
            end
            ISS_RUN: begin
                if (fc_q == 7'(LOAD_WORDS)) begin
                    buf_done[issue_sel_q] = 1'b1;
                end
                if (fc_q == 7'(FRAME_LEN - 1)) begin
                    issue_sel_d = other_sel;
                    fc_d        = '0;
                    if (buf_full[other_sel]) begin
                        buf_start[other_sel] = 1'b1;
                    end else begin
                        ist_d = ISS_IDLE;
                    end
                end else begin
                    fc_d = fc_q + 7'd1;
                end
            end
            default: ist_d = ISS_IDLE;
        endcase
    end

    // Top-level state register; reset abandons any in-flight frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_sel_q  <= 1'b0;
            issue_sel_q <= 1'b0;
            ist_q       <= ISS_IDLE;
            fc_q        <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            fill_sel_q  <= fill_sel_d;
            issue_sel_q <= issue_sel_d;
            ist_q       <= ist_d;
            fc_q        <= fc_d;
            ready_en_q  <= ready_en_d;
        end
    end

    assign running        = (ist_q == ISS_RUN);
    assign rd_idx         = fc_q[3:0] - 4'd1;  // fc 16 wraps to word 15
    assign msg_ready      = ready_en_q && buf_fill_ok[fill_sel_q];
    assign msg_err        = |buf_err;
    assign frame_start    = running && (fc_q == 7'd0);
    assign load7          = running && (fc_q < 7'(LOAD_WORDS));
    assign phase_advance7 = running && ((fc_q == 7'd0) ||
                                        (fc_q == 7'(PHASE_LEN)) ||
                                        (fc_q == 7'(2 * PHASE_LEN)) ||
                                        (fc_q == 7'(3 * PHASE_LEN)));
    assign din            = (running && (fc_q != 7'd0) && (fc_q <= 7'(LOAD_WORDS)))
                            ? buf_rd[issue_sel_q] : 32'h0;

endmodule
